// File: rtl/axis_wrr_arbiter_if.sv
// Request/acknowledge/grant bundle shared by the arbiter and its requesters.
// The wdog_* signals are present only when AXIS_WRR_WDOG_EN is defined.
interface axis_wrr_arbiter_if #(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4
);
  localparam int IDXW = $clog2(PORTS);

  logic [PORTS-1:0]              request;
  logic [PORTS-1:0]              acknowledge;
  logic [PORTS*WEIGHT_WIDTH-1:0] cfg_weight;
  logic [PORTS-1:0]              grant;
  logic                          grant_valid;
  logic [IDXW-1:0]               grant_encoded;
`ifdef AXIS_WRR_WDOG_EN
  logic                          wdog_timeout;
  logic [IDXW-1:0]               wdog_port;
`endif

  // Requester side: drives requests, end-of-packet acks and weights.
  modport master (
    output request, acknowledge, cfg_weight,
`ifdef AXIS_WRR_WDOG_EN
    input  wdog_timeout, wdog_port,
`endif
    input  grant, grant_valid, grant_encoded
  );

  // Arbiter side.
  modport slave (
    input  request, acknowledge, cfg_weight,
`ifdef AXIS_WRR_WDOG_EN
    output wdog_timeout, wdog_port,
`endif
    output grant, grant_valid, grant_encoded
  );
endinterface

// File: rtl/axis_wrr_arbiter.sv
// Packet-level weighted round-robin arbiter for one shared AXI-stream output.
// Define AXIS_WRR_WDOG_EN to add the grant watchdog (TIMEOUT cycles without ack).
module axis_wrr_arbiter #(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_wrr_arbiter_if.slave    arb
);

  localparam int IDXW = $clog2(PORTS);

  if (PORTS < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("axis_wrr_arbiter: PORTS and TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PORTS-1:0]        grant_q, grant_d;
  logic                    valid_q, valid_d;
  logic [IDXW-1:0]         enc_q, enc_d;
  logic [IDXW-1:0]         ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

`ifdef AXIS_WRR_WDOG_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0]           wcnt_q, wcnt_d;
  logic                    wto_q, wto_d;
  logic [IDXW-1:0]         wport_q, wport_d;
`endif

  logic [PORTS-1:0]        eligible;
  logic                    pick_found;
  logic [IDXW-1:0]         pick_idx;
  int unsigned             scan_idx;
  logic                    ack_g;
  logic                    req_g;
  logic                    release_now;

  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] p);
    if (32'(p) == 32'(PORTS - 1)) return '0;
    else                          return p + 1'b1;
  endfunction

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      eligible[i] = arb.request[i] && (arb.cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
    end
  end

  // Rotating scan starting at ptr_q; the index wraps explicitly so a
  // non-power-of-two PORTS never produces an out-of-range port.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= 32'(PORTS)) scan_idx = scan_idx - 32'(PORTS);
      if (!pick_found && eligible[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(scan_idx);
      end
    end
  end

  assign ack_g = arb.acknowledge[enc_q];
  assign req_g = arb.request[enc_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    valid_d     = valid_q;
    enc_d       = enc_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    release_now = 1'b0;
`ifdef AXIS_WRR_WDOG_EN
    wcnt_d      = wcnt_q;
    wto_d       = 1'b0;
    wport_d     = wport_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d           = S_GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          valid_d           = 1'b1;
          enc_d             = pick_idx;
          credit_d          = arb.cfg_weight[pick_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
`ifdef AXIS_WRR_WDOG_EN
          wcnt_d            = '0;
`endif
        end
      end

      S_GRANT, S_HOLD: begin
        if (ack_g) begin
`ifdef AXIS_WRR_WDOG_EN
          wcnt_d = '0;
`endif
          if (credit_q == WEIGHT_WIDTH'(1)) begin
            release_now = 1'b1;
          end else begin
            credit_d = credit_q - 1'b1;
            state_d  = S_HOLD;
          end
`ifdef AXIS_WRR_WDOG_EN
        end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
          release_now = 1'b1;
          wto_d       = 1'b1;
          wport_d     = enc_q;
`endif
        end else begin
`ifdef AXIS_WRR_WDOG_EN
          wcnt_d = wcnt_q + 1'b1;
`endif
          // HOLD lasts one cycle: continue the turn only if the port still asks.
          if (state_q == S_HOLD) begin
            if (req_g) state_d = S_GRANT;
            else       release_now = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (release_now) begin
      state_d = S_IDLE;
      grant_d = '0;
      valid_d = 1'b0;
      enc_d   = '0;
      ptr_d   = wrap_inc(enc_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      enc_q    <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
`ifdef AXIS_WRR_WDOG_EN
      wcnt_q   <= '0;
      wto_q    <= 1'b0;
      wport_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      enc_q    <= enc_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
`ifdef AXIS_WRR_WDOG_EN
      wcnt_q   <= wcnt_d;
      wto_q    <= wto_d;
      wport_q  <= wport_d;
`endif
    end
  end

  assign arb.grant         = grant_q;
  assign arb.grant_valid   = valid_q;
  assign arb.grant_encoded = enc_q;
`ifdef AXIS_WRR_WDOG_EN
  assign arb.wdog_timeout  = wto_q;
  assign arb.wdog_port     = wport_q;
`endif

endmodule

// File: tb/tb_axis_wrr_arbiter.sv
// Randomized and directed checks of axis_wrr_arbiter against a turn-based
// reference model (owner / packets-left / round-robin pointer).
module tb_axis_wrr_arbiter;

  localparam int P       = 4;
  localparam int WW      = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_wrr_arbiter_if #(.PORTS(P), .WEIGHT_WIDTH(WW)) bus ();

  axis_wrr_arbiter #(.PORTS(P), .WEIGHT_WIDTH(WW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  int m_owner;   // -1 when nobody holds the output
  int m_left;    // packets remaining in the current turn
  int m_ptr;     // where the next scan starts
  int m_cnt;     // cycles since grant / last ack
  bit m_gap;     // one-cycle window after a mid-turn packet end
  bit m_wd;
  int m_wdport;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int wfield(input int i);
    return int'(bus.cfg_weight[i*WW +: WW]);
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_left = 0; m_ptr = 0; m_cnt = 0; m_gap = 0; m_wd = 0; m_wdport = 0;
  endfunction

  function automatic void model_release();
    m_ptr   = (m_owner + 1) % P;
    m_owner = -1;
    m_gap   = 0;
  endfunction

  function automatic void model_step();
    bit fire;
    bit found;
    fire  = 0;
    found = 0;
    m_wd  = 0;
`ifdef AXIS_WRR_WDOG_EN
    fire = (m_cnt == TIMEOUT - 1);
`endif
    if (m_owner < 0) begin
      for (int k = 0; k < P; k++) begin
        int i;
        i = (m_ptr + k) % P;
        if (!found && bus.request[i] && wfield(i) != 0) begin
          found = 1; m_owner = i; m_left = wfield(i); m_gap = 0; m_cnt = 0;
        end
      end
    end else if (bus.acknowledge[m_owner]) begin
      m_cnt  = 0;
      m_left = m_left - 1;
      if (m_left == 0) model_release();
      else             m_gap = 1;
    end else if (fire) begin
      m_wd = 1; m_wdport = m_owner;
      model_release();
    end else begin
      m_cnt++;
      if (m_gap) begin
        if (bus.request[m_owner]) m_gap = 0;
        else                      model_release();
      end
    end
  endfunction

  function automatic logic [P-1:0] onehot(input int i);
    logic [P-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic compare_outputs();
    check_eq("grant", 32'(bus.grant), 32'(onehot(m_owner)));
    check_eq("grant_valid", 32'(bus.grant_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) check_eq("grant_encoded", 32'(bus.grant_encoded), 32'(m_owner));
`ifdef AXIS_WRR_WDOG_EN
    check_eq("wdog_timeout", 32'(bus.wdog_timeout), 32'(m_wd));
    if (m_wd) check_eq("wdog_port", 32'(bus.wdog_port), 32'(m_wdport));
`endif
  endtask

  task automatic cycle(input logic [P-1:0] r, input logic [P-1:0] a, input logic [P*WW-1:0] w);
    @(negedge clk);
    bus.request     = r;
    bus.acknowledge = a;
    bus.cfg_weight  = w;
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.request = '0; bus.acknowledge = '0;
    model_reset();
    #1;
    check_eq("rst_grant", 32'(bus.grant), 32'h0);
    check_eq("rst_valid", 32'(bus.grant_valid), 32'h0);
    check_eq("rst_enc", 32'(bus.grant_encoded), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int          seq[$];
  logic [31:0] exp_seq [8];
  logic [P-1:0] a;

  initial begin
    bus.request = '0; bus.acknowledge = '0; bus.cfg_weight = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Alternation with unit weights; ack the owner whenever it holds the grant.
    for (int k = 0; k < 12; k++)
      cycle(4'b0101, onehot(m_owner), 16'h1111);

    // Weight 3 vs 1, ack every fourth cycle: owners at ack time 0,0,0,1,...
    do_reset();
    exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
    seq.delete();
    for (int k = 0; k < 80; k++) begin
      a = '0;
      if (m_owner >= 0 && (k % 4) == 3) begin
        a = onehot(m_owner);
        seq.push_back(int'(bus.grant_encoded));
      end
      cycle(4'b0011, a, 16'h0013);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < seq.size()) check_eq("wrr_seq", 32'(seq[i]), exp_seq[i]);
      else                check_eq("wrr_seq_len", 32'(seq.size()), 32'd8);
    end

    // Request 0 dropped in the hold cycle after its first packet.
    do_reset();
    cycle(4'b0011, 4'b0000, 16'h0013);
    cycle(4'b0011, 4'b0001, 16'h0013);
    cycle(4'b0010, 4'b0000, 16'h0013);
    for (int k = 0; k < 4; k++) cycle(4'b0010, 4'b0000, 16'h0013);

    // Weight 0 masks the port until it is given a weight.
    do_reset();
    for (int k = 0; k < 8; k++) cycle(4'b0100, 4'b0000, 16'h1011);
    for (int k = 0; k < 3; k++) cycle(4'b0100, 4'b0000, 16'h1211);

    // Asynchronous reset in the middle of a packet from port 1.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(4'b0010, 4'b0000, 16'h1111);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_grant", 32'(bus.grant), 32'h0);
    check_eq("async_rst_valid", 32'(bus.grant_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cycle(4'b0010, 4'b0000, 16'h1111);

    // Port 3 granted and never acknowledged; watchdog builds release it.
    do_reset();
    for (int k = 0; k < 22; k++) cycle(4'b1000, 4'b0000, 16'h1111);
    for (int k = 0; k < 4; k++) cycle(4'b1001, 4'b0000, 16'h1111);

    // Randomized traffic with occasional weight changes (including to zero).
    do_reset();
    begin
      logic [P*WW-1:0] w;
      logic [P-1:0]    r;
      w = 16'h2131;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 49) == 0)
          for (int i = 0; i < P; i++) w[i*WW +: WW] = WW'($urandom_range(0, 3));
        r = P'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) r = r | onehot(m_owner);
        a = '0;
        if (m_owner >= 0 && $urandom_range(0, 2) == 0) a = onehot(m_owner);
        if ($urandom_range(0, 4) == 0) a = a | P'($urandom_range(0, 15) & ~32'(onehot(m_owner)));
        cycle(r, a, w);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
